// File: rtl/reg_bus_pkg.sv
// Shared types and defaults for the register-bus initiator.
package reg_bus_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_DATA_W = 2;
  localparam int MAX_RD_LAT     = 7;

endpackage

// File: rtl/reg_bus_master_if.sv
// Command, response and register-bus signals of reg_bus_master, bundled with
// the initiator view (master) and the host/target view (slave).
interface reg_bus_master_if
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WDATA;

  logic              RSP_VALID;
  logic              RSP_READY;
  logic              RSP_WRITE;
  logic [DATA_W-1:0] RSP_RDATA;

  logic              WRITE;
  logic              READ;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [DATA_W-1:0] READ_DATA;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, READ_DATA,
    output CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA,
           WRITE, READ, ADDR, WRITE_DATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, READ_DATA,
    input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA,
           WRITE, READ, ADDR, WRITE_DATA
  );

endinterface

// File: rtl/reg_bus_master.sv
// Single-outstanding register-bus initiator: command in, one bus strobe, response out.
// Define REG_BUS_MASTER_WRITE_ACK_EN to make writes return an acknowledgement response.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  reg_bus_master_if.master bus,
  output logic             BUSY
);

  localparam int         LAT      = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;
  localparam logic [2:0] LAT_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_e            state;
  logic [2:0]        lat_cnt;
  logic              cmd_write_q;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              write_strobe;
  logic              read_strobe;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
  logic              rsp_write;
`endif

  // All outputs are registered; strobes live only for the single ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      cmd_write_q  <= 1'b0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      addr         <= '0;
      write_data   <= '0;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
      rsp_write    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (bus.CMD_VALID && cmd_ready) begin
            cmd_write_q  <= bus.CMD_WRITE;
            cmd_ready    <= 1'b0;
            write_strobe <= bus.CMD_WRITE;
            read_strobe  <= !bus.CMD_WRITE;
            addr         <= bus.CMD_ADDR;
            write_data   <= bus.CMD_WRITE ? bus.CMD_WDATA : '0;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          write_strobe <= 1'b0;
          read_strobe  <= 1'b0;
          write_data   <= '0;
          if (cmd_write_q) begin
            addr <= '0;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
`else
            cmd_ready <= 1'b1;
            state     <= IDLE;
`endif
          end else if (LAT == 0) begin
            // Zero-latency target: read data is valid during the strobe itself.
            addr      <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus.READ_DATA;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
            rsp_write <= 1'b0;
`endif
            state     <= RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            addr      <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus.READ_DATA;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
            rsp_write <= 1'b0;
`endif
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
            rsp_write <= 1'b0;
`endif
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.RSP_VALID  = rsp_valid;
  assign bus.RSP_RDATA  = rsp_rdata;
  assign bus.WRITE      = write_strobe;
  assign bus.READ       = read_strobe;
  assign bus.ADDR       = addr;
  assign bus.WRITE_DATA = write_data;
`ifdef REG_BUS_MASTER_WRITE_ACK_EN
  assign bus.RSP_WRITE  = rsp_write;
`else
  assign bus.RSP_WRITE  = 1'b0;
`endif
  assign BUSY = (state != IDLE);

endmodule
